// File: rtl/scarv_cop_mem_txn_tracker.sv
// Passive monitor for the COP memory port and instruction handshake: records completed
// transactions into a circular history, counts per-instruction traffic, flags protocol violations.
module scarv_cop_mem_txn_tracker #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int SEQW  = 8,
  parameter int CW    = 4
) (
  input  logic                     g_clk,
  input  logic                     g_resetn,
  input  logic                     clr,
  input  logic                     cpu_insn_req,
  input  logic                     cop_insn_ack,
  input  logic                     cop_mem_cen,
  input  logic                     cop_mem_wen,
  input  logic [AW-1:0]            cop_mem_addr,
  input  logic [DW-1:0]            cop_mem_wdata,
  input  logic [DW-1:0]            cop_mem_rdata,
  input  logic [DW/8-1:0]          cop_mem_ben,
  input  logic                     cop_mem_stall,
  input  logic                     cop_mem_error,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic                     rd_wen,
  output logic                     rd_error,
  output logic [AW-1:0]            rd_addr,
  output logic [DW-1:0]            rd_wdata,
  output logic [DW-1:0]            rd_rdata,
  output logic [DW/8-1:0]          rd_ben,
  output logic [SEQW-1:0]          rd_seq,
  output logic [$clog2(DEPTH):0]   hist_count,
  output logic                     hist_wrapped,
  output logic [SEQW-1:0]          insn_seq,
  output logic [CW-1:0]            insn_txn_count,
  output logic                     busy,
  output logic                     viol_error,
  output logic                     viol_stable
);

  localparam int IW = $clog2(DEPTH);
  localparam int BW = DW / 8;
  localparam int EW = 2 + AW + 2 * DW + BW + SEQW;
  localparam logic [IW:0] FULL = (IW + 1)'(DEPTH);

  // state | meaning
  // IDLE  | no request outstanding
  // WAIT  | request latched, waiting for stall to drop
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic            latch_en, complete, wr_en, accept, unstable;
  logic            l_wen;
  logic [AW-1:0]   l_addr;
  logic [DW-1:0]   l_wdata;
  logic [BW-1:0]   l_ben;
  logic [IW-1:0]   wr_ptr, rd_ptr;
  logic            rd_hit;
  logic [EW-1:0]   entry_d, rd_entry_q;
  logic [EW-1:0]   hist_mem [DEPTH];

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: if (cop_mem_cen) begin
        latch_en = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: if (!cop_mem_stall) begin
        complete = 1'b1;
        if (cop_mem_cen) latch_en = 1'b1;
        else             state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q == S_WAIT);
  assign accept   = cpu_insn_req & cop_insn_ack;
  assign wr_en    = complete & ~clr;
  assign unstable = !cop_mem_cen || (cop_mem_wen != l_wen) || (cop_mem_addr != l_addr) ||
                    (cop_mem_wdata != l_wdata) || (cop_mem_ben != l_ben);
  assign entry_d  = {l_wen, cop_mem_error, l_addr, l_wdata, cop_mem_rdata, l_ben, insn_seq};

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      l_wen   <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
      l_ben   <= '0;
    end else if (latch_en) begin
      l_wen   <= cop_mem_wen;
      l_addr  <= cop_mem_addr;
      l_wdata <= cop_mem_wdata;
      l_ben   <= cop_mem_ben;
    end
  end

  // Storage needs no reset: entries beyond hist_count are never exposed.
  always_ff @(posedge g_clk) begin
    if (wr_en) hist_mem[wr_ptr] <= entry_d;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wr_ptr       <= '0;
      hist_count   <= '0;
      hist_wrapped <= 1'b0;
      viol_error   <= 1'b0;
      viol_stable  <= 1'b0;
    end else if (clr) begin
      wr_ptr       <= '0;
      hist_count   <= '0;
      hist_wrapped <= 1'b0;
      viol_error   <= 1'b0;
      viol_stable  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + IW'(1);
        if (hist_count == FULL) hist_wrapped <= 1'b1;
        else                    hist_count   <= hist_count + (IW + 1)'(1);
      end
      if (state_q == S_IDLE && cop_mem_error)               viol_error  <= 1'b1;
      if (state_q == S_WAIT && cop_mem_stall && unstable)   viol_stable <= 1'b1;
    end
  end

  // Accept wins over a same-cycle completion; the entry still carries the old seq.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      insn_seq       <= '0;
      insn_txn_count <= '0;
    end else begin
      if (accept) insn_seq <= insn_seq + SEQW'(1);
      if (accept)                                   insn_txn_count <= '0;
      else if (complete && insn_txn_count != '1)    insn_txn_count <= insn_txn_count + CW'(1);
    end
  end

  assign rd_ptr = wr_ptr - IW'(1) - rd_idx;
  assign rd_hit = ({1'b0, rd_idx} < hist_count);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rd_valid   <= 1'b0;
      rd_entry_q <= '0;
    end else begin
      rd_valid   <= rd_hit;
      rd_entry_q <= rd_hit ? hist_mem[rd_ptr] : '0;
    end
  end

  assign {rd_wen, rd_error, rd_addr, rd_wdata, rd_rdata, rd_ben, rd_seq} = rd_entry_q;

endmodule

// File: tb/tb_scarv_cop_mem_txn_tracker.sv
// Directed bench for scarv_cop_mem_txn_tracker at default parameters (DEPTH=8, 32-bit bus).
module tb_scarv_cop_mem_txn_tracker;

  logic        g_clk = 1'b0;
  logic        g_resetn, clr, cpu_insn_req, cop_insn_ack;
  logic        cop_mem_cen, cop_mem_wen, cop_mem_stall, cop_mem_error;
  logic [31:0] cop_mem_addr, cop_mem_wdata, cop_mem_rdata;
  logic [3:0]  cop_mem_ben;
  logic [2:0]  rd_idx;
  logic        rd_valid, rd_wen, rd_error;
  logic [31:0] rd_addr, rd_wdata, rd_rdata;
  logic [3:0]  rd_ben;
  logic [7:0]  rd_seq, insn_seq;
  logic [3:0]  hist_count, insn_txn_count;
  logic        hist_wrapped, busy, viol_error, viol_stable;

  int n_vec = 0;
  int n_err = 0;

  scarv_cop_mem_txn_tracker dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .clr(clr),
    .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
    .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen), .cop_mem_addr(cop_mem_addr),
    .cop_mem_wdata(cop_mem_wdata), .cop_mem_rdata(cop_mem_rdata), .cop_mem_ben(cop_mem_ben),
    .cop_mem_stall(cop_mem_stall), .cop_mem_error(cop_mem_error),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_wen(rd_wen), .rd_error(rd_error),
    .rd_addr(rd_addr), .rd_wdata(rd_wdata), .rd_rdata(rd_rdata), .rd_ben(rd_ben),
    .rd_seq(rd_seq), .hist_count(hist_count), .hist_wrapped(hist_wrapped),
    .insn_seq(insn_seq), .insn_txn_count(insn_txn_count), .busy(busy),
    .viol_error(viol_error), .viol_stable(viol_stable)
  );

  always #5 g_clk = ~g_clk;

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic do_reset();
    g_resetn = 1'b0;
    clr = 0; cpu_insn_req = 0; cop_insn_ack = 0;
    cop_mem_cen = 0; cop_mem_wen = 0; cop_mem_stall = 0; cop_mem_error = 0;
    cop_mem_addr = 0; cop_mem_wdata = 0; cop_mem_rdata = 0; cop_mem_ben = 0;
    rd_idx = 0;
    tick(); tick();
    g_resetn = 1'b1;
    tick();
  endtask

  // One request, `stalls` stalled cycles, then completion with cen dropped.
  task automatic mem_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] ben, input int stalls, input logic [31:0] rdata);
    cop_mem_cen = 1; cop_mem_wen = wen; cop_mem_addr = addr;
    cop_mem_wdata = wdata; cop_mem_ben = ben; cop_mem_stall = 0;
    tick();
    repeat (stalls) begin
      cop_mem_stall = 1;
      tick();
    end
    cop_mem_stall = 0; cop_mem_cen = 0; cop_mem_rdata = rdata;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (hist_count !== 4'd0) begin n_err++; $display("FAIL reset_hist_count got %0d exp 0", hist_count); end
    n_vec++; if (insn_seq !== 8'd0 || insn_txn_count !== 4'd0) begin n_err++; $display("FAIL reset_insn got seq %0d cnt %0d exp 0 0", insn_seq, insn_txn_count); end
    n_vec++; if ({busy, hist_wrapped, viol_error, viol_stable, rd_valid} !== 5'b0) begin n_err++; $display("FAIL reset_flags got %b exp 00000", {busy, hist_wrapped, viol_error, viol_stable, rd_valid}); end
    n_vec++; if (rd_addr !== 32'd0 || rd_rdata !== 32'd0 || rd_seq !== 8'd0) begin n_err++; $display("FAIL reset_rd got addr %h rdata %h seq %0d exp 0", rd_addr, rd_rdata, rd_seq); end
  endtask

  task automatic test_single_read();
    do_reset();
    cop_mem_cen = 1; cop_mem_wen = 0; cop_mem_addr = 32'h100; cop_mem_ben = 4'hF; cop_mem_wdata = 0;
    tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b exp 1", busy); end
    cop_mem_stall = 1; tick(); tick();
    n_vec++; if (hist_count !== 4'd0) begin n_err++; $display("FAIL single_stall_count got %0d exp 0", hist_count); end
    cop_mem_stall = 0; cop_mem_cen = 0; cop_mem_rdata = 32'hDEADBEEF;
    tick();
    n_vec++; if (hist_count !== 4'd1 || insn_txn_count !== 4'd1 || busy !== 1'b0) begin n_err++; $display("FAIL single_done got count %0d txn %0d busy %b exp 1 1 0", hist_count, insn_txn_count, busy); end
    rd_idx = 0; tick();
    n_vec++; if (rd_valid !== 1'b1 || rd_addr !== 32'h100 || rd_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_rd got v %b addr %h rdata %h exp 1 100 deadbeef", rd_valid, rd_addr, rd_rdata); end
    n_vec++; if (rd_wen !== 1'b0 || rd_seq !== 8'd0 || rd_ben !== 4'hF || rd_error !== 1'b0) begin n_err++; $display("FAIL single_rd_fields got wen %b seq %0d ben %h err %b exp 0 0 f 0", rd_wen, rd_seq, rd_ben, rd_error); end
    rd_idx = 1; tick();
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL single_rd_invalid got %b exp 0", rd_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cop_mem_cen = 1; cop_mem_wen = 1; cop_mem_ben = 4'hF;
    cop_mem_addr = 32'h0; cop_mem_wdata = 32'hA0; tick();
    cop_mem_addr = 32'h4; cop_mem_wdata = 32'hA4; tick();
    cop_mem_addr = 32'h8; cop_mem_wdata = 32'hA8; tick();
    n_vec++; if (busy !== 1'b1 || hist_count !== 4'd2) begin n_err++; $display("FAIL b2b_mid got busy %b count %0d exp 1 2", busy, hist_count); end
    cop_mem_cen = 0; tick();
    n_vec++; if (hist_count !== 4'd3 || insn_txn_count !== 4'd3) begin n_err++; $display("FAIL b2b_count got %0d txn %0d exp 3 3", hist_count, insn_txn_count); end
    rd_idx = 2; tick();
    n_vec++; if (rd_addr !== 32'h0 || rd_wdata !== 32'hA0 || rd_wen !== 1'b1) begin n_err++; $display("FAIL b2b_oldest got addr %h wdata %h wen %b exp 0 a0 1", rd_addr, rd_wdata, rd_wen); end
    rd_idx = 0; tick();
    n_vec++; if (rd_addr !== 32'h8 || rd_wdata !== 32'hA8) begin n_err++; $display("FAIL b2b_newest got addr %h wdata %h exp 8 a8", rd_addr, rd_wdata); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 10; n++) mem_txn(1'b0, 32'(4 * n), 32'd0, 4'hF, 0, 32'(n));
    n_vec++; if (hist_count !== 4'd8 || hist_wrapped !== 1'b1) begin n_err++; $display("FAIL wrap_state got count %0d wrapped %b exp 8 1", hist_count, hist_wrapped); end
    rd_idx = 7; tick();
    n_vec++; if (rd_valid !== 1'b1 || rd_addr !== 32'h8) begin n_err++; $display("FAIL wrap_oldest got v %b addr %h exp 1 8", rd_valid, rd_addr); end
    rd_idx = 0; tick();
    n_vec++; if (rd_addr !== 32'h24 || rd_rdata !== 32'd9) begin n_err++; $display("FAIL wrap_newest got addr %h rdata %0d exp 24 9", rd_addr, rd_rdata); end
    for (int n = 10; n < 17; n++) mem_txn(1'b0, 32'(4 * n), 32'd0, 4'hF, 0, 32'(n));
    n_vec++; if (insn_txn_count !== 4'd15 || hist_count !== 4'd8) begin n_err++; $display("FAIL wrap_saturate got txn %0d count %0d exp 15 8", insn_txn_count, hist_count); end
  endtask

  task automatic test_violations();
    do_reset();
    cop_mem_cen = 1; cop_mem_addr = 32'h10; cop_mem_ben = 4'hF; tick();
    cop_mem_stall = 1; tick();
    n_vec++; if (viol_stable !== 1'b0) begin n_err++; $display("FAIL stable_quiet got %b exp 0", viol_stable); end
    cop_mem_addr = 32'h14; tick();
    n_vec++; if (viol_stable !== 1'b1) begin n_err++; $display("FAIL stable_set got %b exp 1", viol_stable); end
    cop_mem_stall = 0; cop_mem_cen = 0; tick();
    cop_mem_error = 1; tick();
    cop_mem_error = 0;
    n_vec++; if (viol_error !== 1'b1 || hist_count !== 4'd1) begin n_err++; $display("FAIL error_idle got viol %b count %0d exp 1 1", viol_error, hist_count); end
    tick();
    n_vec++; if (viol_stable !== 1'b1 || viol_error !== 1'b1) begin n_err++; $display("FAIL flags_sticky got %b%b exp 11", viol_stable, viol_error); end
    clr = 1; tick(); clr = 0;
    n_vec++; if (viol_stable !== 1'b0 || viol_error !== 1'b0 || hist_count !== 4'd0) begin n_err++; $display("FAIL clr got %b%b count %0d exp 00 0", viol_stable, viol_error, hist_count); end
  endtask

  task automatic test_tagging();
    do_reset();
    cpu_insn_req = 1; cop_insn_ack = 1; tick();
    cpu_insn_req = 0; cop_insn_ack = 0;
    n_vec++; if (insn_seq !== 8'd1) begin n_err++; $display("FAIL tag_first_accept got %0d exp 1", insn_seq); end
    cop_mem_cen = 1; cop_mem_addr = 32'h40; cop_mem_ben = 4'h3; tick();
    cop_mem_cen = 0; cop_mem_stall = 0; cop_mem_error = 1;
    cpu_insn_req = 1; cop_insn_ack = 1; tick();
    cpu_insn_req = 0; cop_insn_ack = 0; cop_mem_error = 0;
    n_vec++; if (insn_seq !== 8'd2 || insn_txn_count !== 4'd0 || hist_count !== 4'd1) begin n_err++; $display("FAIL tag_same_cycle got seq %0d txn %0d count %0d exp 2 0 1", insn_seq, insn_txn_count, hist_count); end
    rd_idx = 0; tick();
    n_vec++; if (rd_seq !== 8'd1 || rd_error !== 1'b1 || rd_ben !== 4'h3) begin n_err++; $display("FAIL tag_entry got seq %0d err %b ben %h exp 1 1 3", rd_seq, rd_error, rd_ben); end
    n_vec++; if (viol_error !== 1'b0) begin n_err++; $display("FAIL tag_error_in_wait got %b exp 0", viol_error); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    cop_mem_cen = 1; cop_mem_addr = 32'h200; cop_mem_ben = 4'hF; tick();
    cop_mem_stall = 1; tick();
    #2 g_resetn = 0;
    #1;
    n_vec++; if (busy !== 1'b0 || hist_count !== 4'd0) begin n_err++; $display("FAIL rst_async got busy %b count %0d exp 0 0", busy, hist_count); end
    cop_mem_cen = 0; cop_mem_stall = 0;
    tick();
    g_resetn = 1;
    tick();
    mem_txn(1'b1, 32'h300, 32'h55, 4'hC, 1, 32'h0);
    n_vec++; if (hist_count !== 4'd1) begin n_err++; $display("FAIL rst_fresh_count got %0d exp 1", hist_count); end
    rd_idx = 0; tick();
    n_vec++; if (rd_addr !== 32'h300 || rd_wdata !== 32'h55) begin n_err++; $display("FAIL rst_fresh_entry got addr %h wdata %h exp 300 55", rd_addr, rd_wdata); end
    rd_idx = 1; tick();
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_only_one got %b exp 0", rd_valid); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wrap();
    test_violations();
    test_tagging();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
